// File: rtl/cpu_pkg.sv
// Shared definitions for the DECA CPU fetch/execute controller.
//   seq_state_t : sequencer states (FETCH1, FETCH2, EXEC1, HALT)
//   CODE_*      : instruction class encodings held in IR'[15:14]
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    EXEC1  = 2'd2,
    HALT   = 2'd3
  } seq_state_t;

  localparam logic [1:0] CODE_JMP  = 2'b00;
  localparam logic [1:0] CODE_NOP  = 2'b01;
  localparam logic [1:0] CODE_HALT = 2'b10;
  localparam logic [1:0] CODE_ARM  = 2'b11;

endpackage

// File: rtl/cpu_flags.sv
// CARRY and SKIP flag flip-flops.
//   clk, reset          : clock, synchronous active-high reset
//   exec1               : ALU execute strobe; gates both flag enables
//   carryout, carryen   : CARRY D / enable from the ALU
//   skipout, skipen     : SKIP D / enable from the ALU
//   squash              : clears SKIP after it has discarded an instruction
//   carrystatus         : CARRY Q
//   skipstatus          : SKIP Q
module cpu_flags (
  input  logic clk,
  input  logic reset,
  input  logic exec1,
  input  logic carryout,
  input  logic carryen,
  input  logic skipout,
  input  logic skipen,
  input  logic squash,
  output logic carrystatus,
  output logic skipstatus
);

  always_ff @(posedge clk) begin
    if (reset) begin
      carrystatus <= 1'b0;
      skipstatus  <= 1'b0;
    end else begin
      if (exec1 && carryen)
        carrystatus <= carryout;
      // squash and exec1 are mutually exclusive, so the order here is moot
      if (squash)
        skipstatus <= 1'b0;
      else if (exec1 && skipen)
        skipstatus <= skipout;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 16-bit DECA CPU.
// Fetches from synchronous program memory, holds IR', strobes the ALU via
// exec1 and executes JMP / NOP / HALT itself.
//   clk, reset            : clock, synchronous active-high reset
//   memaddr, memrd        : program memory address (= PC) and read strobe
//   memdata               : instruction word, valid one cycle after memrd
//   instruction           : IR'
//   exec1                 : ALU execute strobe
//   carrystatus/skipstatus: flag flip-flop outputs
//   carryout/carryen      : CARRY D / enable from the ALU
//   skipout/skipen        : SKIP D / enable from the ALU
//   halted                : high in the HALT state
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] memaddr,
  output logic              memrd,
  input  logic [15:0]       memdata,
  output logic [15:0]       instruction,
  output logic              exec1,
  output logic              carrystatus,
  output logic              skipstatus,
  input  logic              carryout,
  input  logic              carryen,
  input  logic              skipout,
  input  logic              skipen,
  output logic              halted
);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [1:0]        opcode;
  logic              squash;

  assign opcode = ir[15:14];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH1;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH2) begin
        ir <= memdata;
        pc <= pc + ADDR_W'(1);
      end else if (state == EXEC1 && !skipstatus && opcode == CODE_JMP) begin
        pc <= ir[ADDR_W-1:0];
      end
    end
  end

  // Outputs depend only on state, IR' and the SKIP flop, never on inputs.
  always_comb begin
    state_next = state;
    memrd      = 1'b0;
    exec1      = 1'b0;
    halted     = 1'b0;
    squash     = 1'b0;
    case (state)
      FETCH1: begin
        memrd      = 1'b1;
        state_next = FETCH2;
      end
      FETCH2: state_next = EXEC1;
      EXEC1: begin
        state_next = FETCH1;
        if (skipstatus) begin
          squash = 1'b1;
        end else begin
          if (opcode == CODE_ARM)  exec1 = 1'b1;
          if (opcode == CODE_HALT) state_next = HALT;
        end
      end
      HALT: halted = 1'b1;
      default: state_next = FETCH1;
    endcase
  end

  assign memaddr     = pc;
  assign instruction = ir;

  cpu_flags u_flags (
    .clk        (clk),
    .reset      (reset),
    .exec1      (exec1),
    .carryout   (carryout),
    .carryen    (carryen),
    .skipout    (skipout),
    .skipen     (skipen),
    .squash     (squash),
    .carrystatus(carrystatus),
    .skipstatus (skipstatus)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  memaddr;
  logic        memrd;
  logic [15:0] memdata = 16'h0000;
  logic [15:0] instruction;
  logic        exec1;
  logic        carrystatus;
  logic        skipstatus;
  logic        carryout = 1'b0;
  logic        carryen  = 1'b0;
  logic        skipout  = 1'b0;
  logic        skipen   = 1'b0;
  logic        halted;

  logic [15:0] mem [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Synchronous program memory: data appears the cycle after memrd.
  always @(posedge clk) if (memrd) memdata <= mem[memaddr];

  cpu_sequencer #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .memaddr    (memaddr),
    .memrd      (memrd),
    .memdata    (memdata),
    .instruction(instruction),
    .exec1      (exec1),
    .carrystatus(carrystatus),
    .skipstatus (skipstatus),
    .carryout   (carryout),
    .carryen    (carryen),
    .skipout    (skipout),
    .skipen     (skipen),
    .halted     (halted)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000;
  endtask

  // After this returns we are in cycle 0 (FETCH1 of address 0).
  task automatic do_reset();
    carryen = 0; carryout = 0; skipen = 0; skipout = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_nop();
    do_reset();
    checks++; if (memrd !== 1'b1) begin failures++; $display("FAIL reset_memrd got=%b exp=1", memrd); end
    checks++; if (memaddr !== 8'h00) begin failures++; $display("FAIL reset_memaddr got=%h exp=00", memaddr); end
    checks++; if (exec1 !== 1'b0) begin failures++; $display("FAIL reset_exec1 got=%b exp=0", exec1); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", instruction); end
    checks++; if ({carrystatus, skipstatus} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {carrystatus, skipstatus}); end
  endtask

  task automatic test_arm();
    fill_nop(); mem[0] = 16'hC000;
    do_reset();
    checks++; if ({memrd, exec1} !== 2'b10) begin failures++; $display("FAIL arm_c0 got=%b exp=10", {memrd, exec1}); end
    step();
    checks++; if ({memrd, exec1} !== 2'b00) begin failures++; $display("FAIL arm_c1 got=%b exp=00", {memrd, exec1}); end
    step();
    checks++; if (instruction !== 16'hC000) begin failures++; $display("FAIL arm_ir got=%h exp=C000", instruction); end
    checks++; if (exec1 !== 1'b1) begin failures++; $display("FAIL arm_exec1 got=%b exp=1", exec1); end
    checks++; if (memaddr !== 8'h01) begin failures++; $display("FAIL arm_addr_c2 got=%h exp=01", memaddr); end
    step();
    checks++; if ({memrd, exec1, memaddr} !== {2'b10, 8'h01}) begin failures++; $display("FAIL arm_c3 got=%b_%h exp=10_01", {memrd, exec1}, memaddr); end
  endtask

  task automatic test_jmp();
    logic seen;
    fill_nop(); mem[0] = 16'h003A;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (exec1 === 1'b1) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL jmp_exec1 got=%b exp=0", seen); end
    checks++; if ({memrd, memaddr} !== {1'b1, 8'h3A}) begin failures++; $display("FAIL jmp_target got=%b_%h exp=1_3a", memrd, memaddr); end
  endtask

  task automatic test_skip();
    fill_nop(); mem[0] = 16'hC000; mem[1] = 16'hC000; mem[2] = 16'hC000;
    do_reset();
    step(); step();                        // cycle 2: EXEC1 of address 0
    skipen = 1; skipout = 1;
    step();                                // cycle 3
    skipen = 0; skipout = 0;
    checks++; if (skipstatus !== 1'b1) begin failures++; $display("FAIL skip_set got=%b exp=1", skipstatus); end
    step(); step();                        // cycle 5: EXEC1 of address 1
    checks++; if ({skipstatus, exec1} !== 2'b10) begin failures++; $display("FAIL skip_squash got=%b exp=10", {skipstatus, exec1}); end
    step();                                // cycle 6
    checks++; if (skipstatus !== 1'b0) begin failures++; $display("FAIL skip_clear got=%b exp=0", skipstatus); end
    step(); step();                        // cycle 8: EXEC1 of address 2
    checks++; if ({exec1, memaddr} !== {1'b1, 8'h03}) begin failures++; $display("FAIL skip_next got=%b_%h exp=1_03", exec1, memaddr); end
  endtask

  task automatic test_skip_halt();
    // A squashed HALT must not halt.
    fill_nop(); mem[0] = 16'hC000; mem[1] = 16'h8000;
    do_reset();
    step(); step();
    skipen = 1; skipout = 1;
    step();
    skipen = 0; skipout = 0;
    step(); step(); step();                // cycle 6
    checks++; if ({halted, memrd, memaddr} !== {2'b01, 8'h02}) begin failures++; $display("FAIL skip_halt got=%b_%h exp=01_02", {halted, memrd}, memaddr); end
  endtask

  task automatic test_carry();
    fill_nop(); mem[0] = 16'hC000; mem[1] = 16'hC000; mem[2] = 16'hC000;
    do_reset();
    step();                                // cycle 1: FETCH2
    carryen = 1; carryout = 1;
    step();                                // cycle 2
    carryen = 0; carryout = 0;
    checks++; if (carrystatus !== 1'b0) begin failures++; $display("FAIL carry_fetch2 got=%b exp=0", carrystatus); end
    step(); step(); step();                // cycle 5: EXEC1 of address 1
    carryen = 1; carryout = 1;
    step();
    carryen = 0; carryout = 0;
    checks++; if (carrystatus !== 1'b1) begin failures++; $display("FAIL carry_set got=%b exp=1", carrystatus); end
    step(); step();                        // cycle 8: EXEC1 of address 2
    carryen = 1; carryout = 0;
    step();
    carryen = 0;
    checks++; if (carrystatus !== 1'b0) begin failures++; $display("FAIL carry_clear got=%b exp=0", carrystatus); end
  endtask

  task automatic test_wrap();
    fill_nop(); mem[0] = 16'h00FF;
    do_reset();
    step(); step(); step();                // cycle 3: FETCH1 of 0xFF
    checks++; if (memaddr !== 8'hFF) begin failures++; $display("FAIL wrap_jmp got=%h exp=ff", memaddr); end
    step(); step(); step();                // cycle 6
    checks++; if ({memrd, memaddr} !== {1'b1, 8'h00}) begin failures++; $display("FAIL wrap_addr got=%b_%h exp=1_00", memrd, memaddr); end
  endtask

  task automatic test_halt();
    int bad;
    fill_nop(); mem[0] = 16'hC000; mem[1] = 16'h8000;
    do_reset();
    step(); step();                        // cycle 2
    carryen = 1; carryout = 1;
    step();
    carryen = 0; carryout = 0;
    step(); step(); step();                // cycle 6: HALT
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      carryen = 1; skipen = 1; skipout = 1; carryout = 0;
      if ({halted, memrd, exec1, carrystatus, skipstatus} !== 5'b10010 || memaddr !== 8'h02) bad++;
      step();
    end
    carryen = 0; skipen = 0; skipout = 0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad); end
    do_reset();
    checks++; if ({halted, memrd, memaddr, carrystatus, skipstatus} !== {2'b01, 8'h00, 2'b00}) begin
      failures++; $display("FAIL halt_reset got=%b_%h_%b exp=01_00_00", {halted, memrd}, memaddr, {carrystatus, skipstatus});
    end
  endtask

  task automatic test_reset_fetch2();
    fill_nop(); mem[0] = 16'hC000; mem[1] = 16'h003A;
    do_reset();
    step(); step();                        // cycle 2
    carryen = 1; carryout = 1; skipen = 1; skipout = 1;
    step();
    carryen = 0; carryout = 0; skipen = 0; skipout = 0;
    step();                                // cycle 4: FETCH2
    reset = 1;
    step();
    reset = 0;
    checks++; if ({memrd, exec1, halted, memaddr, instruction} !== {3'b100, 8'h00, 16'h0000}) begin
      failures++; $display("FAIL rst_fetch2 got=%b_%h_%h exp=100_00_0000", {memrd, exec1, halted}, memaddr, instruction);
    end
    checks++; if ({carrystatus, skipstatus} !== 2'b00) begin failures++; $display("FAIL rst_fetch2_flags got=%b exp=00", {carrystatus, skipstatus}); end
  endtask

  task automatic test_reset_exec1();
    fill_nop(); mem[0] = 16'hC000;
    do_reset();
    step(); step();                        // cycle 2: EXEC1
    carryen = 1; carryout = 1; skipen = 1; skipout = 1; reset = 1;
    step();
    reset = 0; carryen = 0; carryout = 0; skipen = 0; skipout = 0;
    checks++; if ({carrystatus, skipstatus, memaddr} !== {2'b00, 8'h00}) begin
      failures++; $display("FAIL rst_exec1 got=%b_%h exp=00_00", {carrystatus, skipstatus}, memaddr);
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_jmp();
    test_skip();
    test_skip_halt();
    test_carry();
    test_wrap();
    test_halt();
    test_reset_fetch2();
    test_reset_exec1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
